// File: rtl/hilo_mul_ctrl.sv
// EXE-stage HI/LO owner and multiplier requester: issues multiply-class ops to an
// external multiplier, stalls EXE until the product returns, and commits HI/LO or rd.
module hilo_mul_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [3:0]  op_code,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        exe_stall,
  output logic [31:0] exe_result,
  output logic        mul_req,
  output logic        mul_cancel,
  output logic        mul_signed,
  output logic        mul_accumulate,
  output logic        mul_add_sub,
  output logic [63:0] mul_oprand,
  output logic [63:0] mul_hilo,
  input  logic        mul_oprand_ok,
  input  logic        mul_data_ok,
  input  logic [63:0] mul_res
);

  localparam int unsigned DW  = 32;
  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] OP_MULT  = 4'd1;
  localparam logic [OPW-1:0] OP_MULTU = 4'd2;
  localparam logic [OPW-1:0] OP_MADD  = 4'd3;
  localparam logic [OPW-1:0] OP_MADDU = 4'd4;
  localparam logic [OPW-1:0] OP_MSUB  = 4'd5;
  localparam logic [OPW-1:0] OP_MSUBU = 4'd6;
  localparam logic [OPW-1:0] OP_MTHI  = 4'd7;
  localparam logic [OPW-1:0] OP_MTLO  = 4'd8;
  localparam logic [OPW-1:0] OP_MFHI  = 4'd9;
  localparam logic [OPW-1:0] OP_MFLO  = 4'd10;
  localparam logic [OPW-1:0] OP_MUL   = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY} state_t;

  state_t          state;
  logic [OPW-1:0]  op_r;
  logic [DW-1:0]   opa_r;
  logic [DW-1:0]   opb_r;
  logic [DW-1:0]   hi;
  logic [DW-1:0]   lo;

  logic is_mc;
  logic idle_go;
  logic start_mc;
  logic commit;

  assign is_mc    = (op_code >= OP_MULT && op_code <= OP_MSUBU) || (op_code == OP_MUL);
  assign idle_go  = (state == S_IDLE) && op_valid && !flush;
  assign start_mc = idle_go && is_mc;
  assign commit   = (state == S_BUSY) && mul_data_ok && !flush;

  // Multiplier request side is driven purely from latched op/operands and the
  // architectural HI/LO, which cannot change outside IDLE, so it stays stable.
  assign mul_req        = (state == S_REQ);
  assign mul_cancel     = flush && (state != S_IDLE);
  assign mul_signed     = (op_r == OP_MULT) || (op_r == OP_MADD) || (op_r == OP_MSUB);
  assign mul_accumulate = (op_r >= OP_MADD) && (op_r <= OP_MSUBU);
  assign mul_add_sub    = (op_r == OP_MADD) || (op_r == OP_MADDU);
  assign mul_oprand     = {opb_r, opa_r};
  assign mul_hilo       = {hi, lo};

  assign exe_stall = start_mc
                  || (state == S_REQ)
                  || ((state == S_BUSY) && !mul_data_ok);

  // MF reads see the register directly; a commit the cycle before is already visible.
  always_comb begin
    exe_result = '0;
    if (idle_go && op_code == OP_MFHI) begin
      exe_result = hi;
    end else if (idle_go && op_code == OP_MFLO) begin
      exe_result = lo;
    end else if (commit && op_r == OP_MUL) begin
      exe_result = mul_res[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      op_r  <= '0;
      opa_r <= '0;
      opb_r <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_mc) begin
            op_r  <= op_code;
            opa_r <= src_a;
            opb_r <= src_b;
            state <= S_REQ;
          end else if (idle_go && op_code == OP_MTHI) begin
            hi <= src_a;
          end else if (idle_go && op_code == OP_MTLO) begin
            lo <= src_a;
          end
        end
        S_REQ: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (mul_oprand_ok) begin
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (mul_data_ok) begin
            if (op_r != OP_MUL) begin
              hi <= mul_res[63:32];
              lo <= mul_res[31:0];
            end
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Directed bench for hilo_mul_ctrl with a behavioural multiplier of configurable
// accept delay and data latency.
module tb_hilo_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [3:0]  op_code;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        exe_stall;
  logic [31:0] exe_result;
  logic        mul_req;
  logic        mul_cancel;
  logic        mul_signed;
  logic        mul_accumulate;
  logic        mul_add_sub;
  logic [63:0] mul_oprand;
  logic [63:0] mul_hilo;
  logic        mul_oprand_ok;
  logic        mul_data_ok;
  logic [63:0] mul_res;

  int vectors = 0;
  int errors  = 0;

  hilo_mul_ctrl dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .src_a(src_a), .src_b(src_b), .flush(flush), .exe_stall(exe_stall),
    .exe_result(exe_result), .mul_req(mul_req), .mul_cancel(mul_cancel),
    .mul_signed(mul_signed), .mul_accumulate(mul_accumulate),
    .mul_add_sub(mul_add_sub), .mul_oprand(mul_oprand), .mul_hilo(mul_hilo),
    .mul_oprand_ok(mul_oprand_ok), .mul_data_ok(mul_data_ok), .mul_res(mul_res)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: product (optionally accumulated into HI/LO).
  function automatic logic [63:0] mul_model(input logic [63:0] opr, input logic [63:0] hilo,
                                            input logic sgn, input logic acc, input logic addsub);
    logic [63:0] x, y, p;
    x = sgn ? {{32{opr[31]}}, opr[31:0]}  : {32'd0, opr[31:0]};
    y = sgn ? {{32{opr[63]}}, opr[63:32]} : {32'd0, opr[63:32]};
    p = x * y;
    if (acc) p = addsub ? (hilo + p) : (hilo - p);
    return p;
  endfunction

  task automatic idle_inputs();
    op_valid = 1'b0; op_code = 4'd0; src_a = '0; src_b = '0;
    flush = 1'b0; mul_oprand_ok = 1'b0; mul_data_ok = 1'b0; mul_res = '0;
  endtask

  // Runs one multiply-class op to commit; reports stall cycles, commit-cycle result
  // and whether the request stayed high with stable operands while waiting.
  task automatic run_mc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int ok_delay, input int lat,
                        output int stalls, output logic [31:0] res, output logic req_ok);
    logic [63:0] pend;
    bit done;
    stalls = 0; res = '0; req_ok = 1'b1; pend = '0; done = 0;
    @(negedge clk);
    idle_inputs();
    op_valid = 1'b1; op_code = op; src_a = a; src_b = b;
    for (int k = 0; k < 60 && !done; k++) begin
      if (k > 0) @(negedge clk);
      mul_data_ok = (k == ok_delay + 1 + lat);
      mul_res     = mul_data_ok ? pend : 64'd0;
      #1;
      if (k >= 1 && k <= ok_delay + 1)
        req_ok = req_ok & (mul_req === 1'b1) & (mul_oprand === {b, a});
      if (mul_req && k >= ok_delay + 1) begin
        mul_oprand_ok = 1'b1;
        pend = mul_model(mul_oprand, mul_hilo, mul_signed, mul_accumulate, mul_add_sub);
      end else begin
        mul_oprand_ok = 1'b0;
      end
      #1;
      if (exe_stall === 1'b1) stalls++;
      else begin
        res = exe_result;
        done = 1;
      end
      @(posedge clk);
    end
    if (!done) begin
      vectors++; errors++;
      $display("FAIL run_mc_timeout op=%0d: commit never observed", op);
    end
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    @(negedge clk);
    idle_inputs();
    op_valid = 1'b1; op_code = 4'd9;
    #1 h = exe_result;
    op_code = 4'd10;
    #1 l = exe_result;
    op_valid = 1'b0; op_code = 4'd0;
  endtask

  task automatic do_mt(input logic [3:0] op, input logic [31:0] v, input logic fl);
    @(negedge clk);
    idle_inputs();
    op_valid = 1'b1; op_code = op; src_a = v; flush = fl;
    @(posedge clk);
  endtask

  // Brings a MULT 2*3 into BUSY; returns just after the edge that enters BUSY.
  task automatic start_to_busy();
    @(negedge clk);
    idle_inputs();
    op_valid = 1'b1; op_code = 4'd1; src_a = 32'd2; src_b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    #1 mul_oprand_ok = mul_req;
    @(posedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] h, l;
    vectors++;
    if (mul_req !== 1'b0 || mul_cancel !== 1'b0 || exe_stall !== 1'b0 || exe_result !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b cancel=%b stall=%b result=%h, want 0 0 0 0",
               mul_req, mul_cancel, exe_stall, exe_result);
    end
    read_hilo(h, l);
    vectors++;
    if (h !== 32'd0 || l !== 32'd0) begin
      errors++; $display("FAIL reset_hilo: hi=%h lo=%h, want 0 0", h, l);
    end
  endtask

  task automatic test_mult();
    int s; logic [31:0] r, h, l; logic q;
    run_mc(4'd1, 32'hFFFF_FFFF, 32'd2, 0, 2, s, r, q);
    read_hilo(h, l);
    vectors++;
    if (s !== 3) begin errors++; $display("FAIL mult_stall: got %0d want 3", s); end
    vectors++;
    if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL mult_hilo: hi=%h lo=%h want ffffffff fffffffe", h, l);
    end
    run_mc(4'd2, 32'hFFFF_FFFF, 32'd2, 0, 2, s, r, q);
    read_hilo(h, l);
    vectors++;
    if (h !== 32'h0000_0001 || l !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL multu_hilo: hi=%h lo=%h want 00000001 fffffffe", h, l);
    end
  endtask

  task automatic test_madd_msub();
    int s; logic [31:0] r, h, l; logic q;
    do_mt(4'd7, 32'd0, 1'b0);
    do_mt(4'd8, 32'd10, 1'b0);
    read_hilo(h, l);
    vectors++;
    if (h !== 32'd0 || l !== 32'd10) begin
      errors++; $display("FAIL mthi_mtlo: hi=%h lo=%h want 0 a", h, l);
    end
    run_mc(4'd3, 32'd3, 32'd4, 0, 4, s, r, q);
    read_hilo(h, l);
    vectors++;
    if (s !== 5) begin errors++; $display("FAIL madd_stall: got %0d want 5", s); end
    vectors++;
    if (h !== 32'd0 || l !== 32'h16) begin
      errors++; $display("FAIL madd_hilo: hi=%h lo=%h want 0 16", h, l);
    end
    run_mc(4'd6, 32'hFFFF_FFFF, 32'd1, 0, 2, s, r, q);
    read_hilo(h, l);
    vectors++;
    if (h !== 32'hFFFF_FFFF || l !== 32'h0000_0017) begin
      errors++; $display("FAIL msubu_hilo: hi=%h lo=%h want ffffffff 00000017", h, l);
    end
  endtask

  task automatic test_mul();
    int s; logic [31:0] r, h, l; logic q;
    run_mc(4'd11, 32'd7, 32'hFFFF_FFFD, 0, 2, s, r, q);
    vectors++;
    if (r !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result: got %h want ffffffeb", r); end
    read_hilo(h, l);
    vectors++;
    if (h !== 32'hFFFF_FFFF || l !== 32'h0000_0017) begin
      errors++; $display("FAIL mul_hilo_kept: hi=%h lo=%h want ffffffff 00000017", h, l);
    end
  endtask

  task automatic test_delayed_ok();
    int s; logic [31:0] r, h, l; logic q;
    run_mc(4'd2, 32'd5, 32'd6, 3, 3, s, r, q);
    vectors++;
    if (q !== 1'b1) begin errors++; $display("FAIL req_hold: stable=%b want 1", q); end
    vectors++;
    if (s !== 7) begin errors++; $display("FAIL delayed_stall: got %0d want 7", s); end
    read_hilo(h, l);
    vectors++;
    if (h !== 32'd0 || l !== 32'h1E) begin
      errors++; $display("FAIL delayed_hilo: hi=%h lo=%h want 0 1e", h, l);
    end
  endtask

  task automatic test_flush(input logic with_data);
    logic [31:0] h, l;
    start_to_busy();
    @(negedge clk);
    mul_oprand_ok = 1'b0; flush = 1'b1;
    mul_data_ok = with_data; mul_res = 64'hDEAD_BEEF_1234_5678;
    #1;
    vectors++;
    if (mul_cancel !== 1'b1 || exe_result !== 32'd0) begin
      errors++; $display("FAIL flush_cancel(data=%b): cancel=%b result=%h want 1 0", with_data, mul_cancel, exe_result);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (mul_cancel !== 1'b0 || exe_stall !== 1'b0 || mul_req !== 1'b0) begin
      errors++; $display("FAIL flush_after(data=%b): cancel=%b stall=%b req=%b want 0 0 0",
                         with_data, mul_cancel, exe_stall, mul_req);
    end
    read_hilo(h, l);
    vectors++;
    if (h !== 32'd0 || l !== 32'h1E) begin
      errors++; $display("FAIL flush_hilo(data=%b): hi=%h lo=%h want 0 1e", with_data, h, l);
    end
  endtask

  task automatic test_flush_idle();
    logic [31:0] h, l;
    do_mt(4'd7, 32'h1234, 1'b1);
    @(negedge clk);
    idle_inputs();
    op_valid = 1'b1; op_code = 4'd1; src_a = 32'd9; src_b = 32'd9; flush = 1'b1;
    #1;
    vectors++;
    if (exe_stall !== 1'b0 || mul_cancel !== 1'b0) begin
      errors++; $display("FAIL flush_idle_start: stall=%b cancel=%b want 0 0", exe_stall, mul_cancel);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (mul_req !== 1'b0) begin errors++; $display("FAIL flush_idle_req: req=%b want 0", mul_req); end
    read_hilo(h, l);
    vectors++;
    if (h !== 32'd0 || l !== 32'h1E) begin
      errors++; $display("FAIL flush_idle_mt: hi=%h lo=%h want 0 1e", h, l);
    end
  endtask

  task automatic test_reset_busy();
    logic [31:0] h, l;
    do_mt(4'd7, 32'hAAAA_5555, 1'b0);
    start_to_busy();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (mul_req !== 1'b0 || exe_stall !== 1'b0) begin
      errors++; $display("FAIL reset_busy_ctrl: req=%b stall=%b want 0 0", mul_req, exe_stall);
    end
    read_hilo(h, l);
    vectors++;
    if (h !== 32'd0 || l !== 32'd0) begin
      errors++; $display("FAIL reset_busy_hilo: hi=%h lo=%h want 0 0", h, l);
    end
  endtask

  task automatic test_back_to_back();
    int s; logic [31:0] r, h, l; logic q;
    run_mc(4'd1, 32'd6, 32'd7, 0, 1, s, r, q);
    read_hilo(h, l);
    vectors++;
    if (s !== 2) begin errors++; $display("FAIL b2b_stall: got %0d want 2", s); end
    vectors++;
    if (h !== 32'd0 || l !== 32'h2A) begin
      errors++; $display("FAIL b2b_read: hi=%h lo=%h want 0 2a", h, l);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    test_reset();
    test_mult();
    test_madd_msub();
    test_mul();
    test_delayed_ok();
    test_flush(1'b0);
    test_flush(1'b1);
    test_flush_idle();
    test_reset_busy();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
